// File: rtl/matrix_mult_pkg.sv
// Shared types and constants for the matrix_mult_seq control sequencer.
// The job config layout and the phase enum live here so that the sequencer,
// its mask generator and any register block agree on one definition.
package matrix_mult_pkg;

  localparam int MM_ROW       = 4;
  localparam int MM_COL       = 4;
  localparam int MM_W_SIZE    = 512;
  localparam int MM_I_SIZE    = 512;
  localparam int MM_O_SIZE    = 512;
  localparam int MM_MEM_LAT   = 1;
  localparam int MM_MAX_TILES = 4;

  localparam int MM_W_AW    = $clog2(MM_W_SIZE);
  localparam int MM_I_AW    = $clog2(MM_I_SIZE);
  localparam int MM_O_AW    = $clog2(MM_O_SIZE);
  localparam int MM_WCOLS_W = $clog2(MM_COL * MM_MAX_TILES) + 1;
  // One extra bit so ceil(w_cols/COL) never overflows for the widest w_cols.
  localparam int MM_TILES_W = MM_WCOLS_W + 1;
  localparam int MM_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    IN_ONLY,
    IN_OUT,
    OUT_ONLY,
    DONE
  } state_struct;

  typedef struct packed {
    logic [MM_W_AW-1:0]    w_rows;
    logic [MM_WCOLS_W-1:0] w_cols;
    logic [MM_I_AW-1:0]    i_rows;
    logic [MM_W_AW-1:0]    w_offset;
    logic [MM_I_AW-1:0]    i_offset;
    logic [MM_O_AW-1:0]    psum_offset;
    logic [MM_O_AW-1:0]    o_offset;
    logic                  accum_en;
  } mm_seq_cfg_t;

  // Compute-phase state for compute cycle c: inputs stream while c < iRows,
  // outputs stream from lat onwards, everything else is the output tail.
  function automatic state_struct mm_phase(input logic [MM_CNT_W-1:0] c,
                                           input logic [MM_CNT_W-1:0] iRows,
                                           input logic [MM_CNT_W-1:0] lat);
    if (c >= iRows) return OUT_ONLY;
    return (c < lat) ? IN_ONLY : IN_OUT;
  endfunction

endpackage

// File: rtl/mm_seq_mask_gen.sv
// Per-column output write mask. Every tile writes all columns except the
// last one, which only writes the columns that still exist in the weight
// matrix (w_cols need not be a multiple of COL).
module mm_seq_mask_gen #(
  parameter int COL     = 4,
  parameter int TIW     = 2,
  parameter int TW      = 6,
  parameter int WCOLS_W = 5
) (
  input  logic [TIW-1:0]     tile_idx_i,
  input  logic [TW-1:0]      tiles_i,
  input  logic [WCOLS_W-1:0] w_cols_i,
  output logic [COL-1:0]     wmask_o
);

  // Trim the mask only on the final tile of the job.
  always_comb begin
    wmask_o = '1;
    if (TW'(tile_idx_i) + TW'(1) == tiles_i) begin
      for (int j = 0; j < COL; j++) begin
        wmask_o[j] = (int'(tile_idx_i) * COL + j) < int'(w_cols_i);
      end
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Control sequencer for the ROW x COL weight-stationary systolic array.
// Tiles wide weight matrices into COL-wide column tiles, loads each tile,
// streams inputs, reads partial sums and writes outputs with column masks.
// Optional build macro MM_SEQ_PERF_EN adds busy/stall cycle counters.
module matrix_mult_seq
  import matrix_mult_pkg::*;
#(
  parameter int ROW       = MM_ROW,
  parameter int COL       = MM_COL,
  parameter int W_SIZE    = MM_W_SIZE,
  parameter int I_SIZE    = MM_I_SIZE,
  parameter int O_SIZE    = MM_O_SIZE,
  parameter int MEM_LAT   = MM_MEM_LAT,
  parameter int MAX_TILES = MM_MAX_TILES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  mm_seq_cfg_t                 cfg,
  input  logic                        stall,
  output logic                        w_ren,
  output logic [$clog2(W_SIZE)-1:0]   w_addr,
  output logic                        weight_push,
  output logic                        i_ren,
  output logic [$clog2(I_SIZE)-1:0]   i_addr,
  output logic                        psum_ren,
  output logic [$clog2(O_SIZE)-1:0]   psum_addr,
  output logic                        o_wen,
  output logic [$clog2(O_SIZE)-1:0]   o_addr,
  output logic [COL-1:0]              o_wmask,
  output state_struct                 state,
  output logic [((MAX_TILES > 1) ? $clog2(MAX_TILES) : 1)-1:0] tile_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
`ifdef MM_SEQ_PERF_EN
  ,
  output logic [31:0]                 perf_busy_cyc,
  output logic [31:0]                 perf_stall_cyc
`endif
);

  localparam int WAW = $clog2(W_SIZE);
  localparam int IAW = $clog2(I_SIZE);
  localparam int OAW = $clog2(O_SIZE);
  localparam int TIW = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;
  localparam int TW  = MM_TILES_W;
  localparam int CW  = MM_CNT_W;

  // Array fill/drain latency; psum reads lead output writes by MEM_LAT.
  localparam logic [CW-1:0] LAT_C   = CW'(ROW + COL + MEM_LAT);
  localparam logic [CW-1:0] PLEAD_C = CW'(ROW + COL);
  localparam logic [CW-1:0] ML_C    = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_struct        state_q;
  mm_seq_cfg_t        cfg_q;
  logic [TIW-1:0]     tile_idx_q;
  logic [TW-1:0]      tiles_q;
  logic               err_q;
  logic [CW-1:0]      k_q;
  logic [CW-1:0]      c_q;

  logic [TW-1:0]      tilesNew;
  logic               cfgBad;
  logic [CW-1:0]      wRows;
  logic [CW-1:0]      iRows;
  logic               inLoad;
  logic               inCompute;
  logic               wReq;
  logic               pushReq;
  logic               iReq;
  logic               oReq;
  logic               pReq;

  assign tilesNew = (TW'(cfg.w_cols) + TW'(COL - 1)) / TW'(COL);
  assign cfgBad   = (cfg.w_rows == '0) || (cfg.i_rows == '0) ||
                    (cfg.w_cols == '0) || (tilesNew > TW'(MAX_TILES));

  assign wRows     = CW'(cfg_q.w_rows);
  assign iRows     = CW'(cfg_q.i_rows);
  assign inLoad    = (state_q == LOAD);
  assign inCompute = (state_q == IN_ONLY) || (state_q == IN_OUT) || (state_q == OUT_ONLY);

  assign wReq    = inLoad && (k_q < wRows);
  assign pushReq = inLoad && (k_q >= ML_C) && (k_q < wRows + ML_C);
  assign iReq    = inCompute && (c_q < iRows);
  assign oReq    = inCompute && (c_q >= LAT_C) && (c_q < LAT_C + iRows);
  assign pReq    = inCompute && cfg_q.accum_en &&
                   (c_q >= PLEAD_C) && (c_q < PLEAD_C + iRows);

  // Stall masks enables only; addresses stay put so the sequence resumes intact.
  assign w_ren       = wReq && !stall;
  assign weight_push = pushReq && !stall;
  assign i_ren       = iReq && !stall;
  assign o_wen       = oReq && !stall;
  assign psum_ren    = pReq && !stall;

  assign w_addr    = wReq ? (WAW'(cfg_q.w_offset) + WAW'(tile_idx_q) * WAW'(cfg_q.w_rows) +
                             WAW'(k_q)) : '0;
  assign i_addr    = iReq ? (IAW'(cfg_q.i_offset) + IAW'(c_q)) : '0;
  assign o_addr    = oReq ? (OAW'(cfg_q.o_offset) + OAW'(tile_idx_q) * OAW'(cfg_q.i_rows) +
                             OAW'(c_q - LAT_C)) : '0;
  assign psum_addr = pReq ? (OAW'(cfg_q.psum_offset) + OAW'(tile_idx_q) * OAW'(cfg_q.i_rows) +
                             OAW'(c_q - PLEAD_C)) : '0;

  assign state    = state_q;
  assign tile_idx = tile_idx_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE) && !stall;
  assign cfg_err  = done && err_q;

  mm_seq_mask_gen #(
    .COL     (COL),
    .TIW     (TIW),
    .TW      (TW),
    .WCOLS_W (MM_WCOLS_W)
  ) u_mask_gen (
    .tile_idx_i (tile_idx_q),
    .tiles_i    (tiles_q),
    .w_cols_i   (cfg_q.w_cols),
    .wmask_o    (o_wmask)
  );

  // Job FSM: accept config, load each tile, run its compute window, repeat per tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      tile_idx_q <= '0;
      tiles_q    <= '0;
      err_q      <= 1'b0;
      k_q        <= '0;
      c_q        <= '0;
    end else if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cfg_q      <= cfg;
            tiles_q    <= tilesNew;
            tile_idx_q <= '0;
            k_q        <= '0;
            c_q        <= '0;
            err_q      <= cfgBad;
            state_q    <= cfgBad ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (k_q == wRows + ML_C - ONE_C) begin
            k_q     <= '0;
            c_q     <= '0;
            state_q <= IN_ONLY;
          end else begin
            k_q <= k_q + ONE_C;
          end
        end
        IN_ONLY, IN_OUT, OUT_ONLY: begin
          if (c_q == LAT_C + iRows - ONE_C) begin
            if (TW'(tile_idx_q) + TW'(1) < tiles_q) begin
              tile_idx_q <= tile_idx_q + TIW'(1);
              k_q        <= '0;
              c_q        <= '0;
              state_q    <= LOAD;
            end else begin
              state_q <= DONE;
            end
          end else begin
            c_q     <= c_q + ONE_C;
            state_q <= mm_phase(c_q + ONE_C, iRows, LAT_C);
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MM_SEQ_PERF_EN
  logic [31:0] perfBusy_q;
  logic [31:0] perfStall_q;

  // Saturating activity counters, restarted by each accepted job.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfBusy_q  <= '0;
      perfStall_q <= '0;
    end else if (state_q == IDLE && start && !stall) begin
      perfBusy_q  <= '0;
      perfStall_q <= '0;
    end else if (state_q != IDLE) begin
      if (perfBusy_q != '1) perfBusy_q <= perfBusy_q + 32'd1;
      if (stall && perfStall_q != '1) perfStall_q <= perfStall_q + 32'd1;
    end
  end

  assign perf_busy_cyc  = perfBusy_q;
  assign perf_stall_cyc = perfStall_q;
`endif

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq (built with MEM_LAT=2).
// A schedule model expands each job config into the expected per-cycle
// enables/addresses; table rows add hand-computed job-level totals.
`timescale 1ns/1ps
module tb_matrix_mult_seq;
  import matrix_mult_pkg::*;

  localparam int ROW       = 4;
  localparam int COL       = 4;
  localparam int W_SIZE    = 512;
  localparam int I_SIZE    = 512;
  localparam int O_SIZE    = 512;
  localparam int MEM_LAT   = 2;
  localparam int MAX_TILES = 4;
  localparam int LAT       = ROW + COL + MEM_LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  mm_seq_cfg_t cfg;
  logic        w_ren, weight_push, i_ren, psum_ren, o_wen;
  logic [8:0]  w_addr, i_addr, psum_addr, o_addr;
  logic [3:0]  o_wmask;
  state_struct state;
  logic [1:0]  tile_idx;
  logic        busy, done, cfg_err;
`ifdef MM_SEQ_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  matrix_mult_seq #(
    .ROW(ROW), .COL(COL), .W_SIZE(W_SIZE), .I_SIZE(I_SIZE), .O_SIZE(O_SIZE),
    .MEM_LAT(MEM_LAT), .MAX_TILES(MAX_TILES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg), .stall(stall),
    .w_ren(w_ren), .w_addr(w_addr), .weight_push(weight_push),
    .i_ren(i_ren), .i_addr(i_addr), .psum_ren(psum_ren), .psum_addr(psum_addr),
    .o_wen(o_wen), .o_addr(o_addr), .o_wmask(o_wmask), .state(state),
    .tile_idx(tile_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef MM_SEQ_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  typedef struct packed {
    logic       wr;
    logic [8:0] wa;
    logic       push;
    logic       ir;
    logic [8:0] ia;
    logic       pr;
    logic [8:0] pa;
    logic       ow;
    logic [8:0] oa;
    logic [3:0] mk;
    logic       dn;
    logic       er;
  } sig_t;

  typedef struct {
    mm_seq_cfg_t c;
    int          len;
    int          err;
    int          owen;
    int          wren;
    int          iren;
    int          pren;
    logic [3:0]  mask;
    int          lastO;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  sig_t expQ[$];
  int   obsLen, obsErr, obsOwen, obsWren, obsIren, obsPren, obsLastO;
  int   obsFirstW, obsFirstI, obsFirstO;
  logic [3:0] obsMask;
  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  function automatic mm_seq_cfg_t mkCfg(input int wr, input int wc, input int ir, input int wo,
                                        input int io, input int po, input int oo, input int acc);
    mm_seq_cfg_t c;
    c.w_rows      = MM_W_AW'(wr);
    c.w_cols      = MM_WCOLS_W'(wc);
    c.i_rows      = MM_I_AW'(ir);
    c.w_offset    = MM_W_AW'(wo);
    c.i_offset    = MM_I_AW'(io);
    c.psum_offset = MM_O_AW'(po);
    c.o_offset    = MM_O_AW'(oo);
    c.accum_en    = (acc != 0);
    return c;
  endfunction

  function automatic logic [3:0] maskFor(input int t, input int tiles, input int wc);
    logic [3:0] m;
    for (int j = 0; j < COL; j++) m[j] = (t < tiles - 1) || (t * COL + j < wc);
    return m;
  endfunction

  // Expand a config into the per-cycle schedule the sequencer must produce.
  task automatic buildExpect(input mm_seq_cfg_t c);
    int   tiles, wr, ir, wc;
    sig_t s;
    wr = int'(c.w_rows);
    ir = int'(c.i_rows);
    wc = int'(c.w_cols);
    tiles = (wc + COL - 1) / COL;
    expQ.delete();
    if (wr == 0 || ir == 0 || wc == 0 || tiles > MAX_TILES) begin
      s = '0; s.dn = 1'b1; s.er = 1'b1;
      expQ.push_back(s);
      return;
    end
    for (int t = 0; t < tiles; t++) begin
      for (int k = 0; k < wr + MEM_LAT; k++) begin
        s = '0;
        if (k < wr) begin
          s.wr = 1'b1;
          s.wa = 9'((int'(c.w_offset) + t * wr + k) % W_SIZE);
        end
        s.push = (k >= MEM_LAT);
        expQ.push_back(s);
      end
      for (int cy = 0; cy < LAT + ir; cy++) begin
        s = '0;
        if (cy < ir) begin
          s.ir = 1'b1;
          s.ia = 9'((int'(c.i_offset) + cy) % I_SIZE);
        end
        if (cy >= LAT) begin
          s.ow = 1'b1;
          s.oa = 9'((int'(c.o_offset) + t * ir + cy - LAT) % O_SIZE);
          s.mk = maskFor(t, tiles, wc);
        end
        if (c.accum_en && cy + MEM_LAT >= LAT && cy + MEM_LAT < LAT + ir) begin
          s.pr = 1'b1;
          s.pa = 9'((int'(c.psum_offset) + t * ir + cy + MEM_LAT - LAT) % O_SIZE);
        end
        expQ.push_back(s);
      end
    end
    s = '0; s.dn = 1'b1;
    expQ.push_back(s);
  endtask

  function automatic sig_t actSig();
    sig_t s;
    s = '0;
    s.wr = w_ren;       if (w_ren) s.wa = w_addr;
    s.push = weight_push;
    s.ir = i_ren;       if (i_ren) s.ia = i_addr;
    s.pr = psum_ren;    if (psum_ren) s.pa = psum_addr;
    s.ow = o_wen;
    if (o_wen) begin s.oa = o_addr; s.mk = o_wmask; end
    s.dn = done;
    s.er = cfg_err;
    return s;
  endfunction

  function automatic mm_seq_cfg_t randCfgBits();
    logic [63:0] r;
    mm_seq_cfg_t c;
    r = {$urandom, $urandom};
    c = r[$bits(mm_seq_cfg_t)-1:0];
    return c;
  endfunction

  // Run one job: cycle 0 presents start, later cycles scramble cfg and apply stall/restart.
  task automatic applyStimulus(input mm_seq_cfg_t c, input int stallAt, input int stallLen,
                               input int restartAt, input string tag);
    int   cyc;
    bit   fin;
    sig_t e, a;
    buildExpect(c);
    obsLen = -1; obsErr = 0; obsOwen = 0; obsWren = 0; obsIren = 0; obsPren = 0;
    obsLastO = 0; obsMask = '0; obsFirstW = -1; obsFirstI = -1; obsFirstO = -1;
    @(negedge clk);
    start = 1'b1; cfg = c; stall = 1'b0;
    #1 checkOutput({tag, " idle-before-start"}, 64'(busy), 64'(0));
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restartAt);
      cfg   = randCfgBits();
      stall = (cyc >= stallAt) && (cyc < stallAt + stallLen);
      #1;
      a = actSig();
      if (stall) begin
        checkOutput($sformatf("%s stalled cyc%0d", tag, cyc), 64'(a), 64'(0));
      end else if (expQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL %s overrun cyc%0d: got activity 0x%0h, wanted job already done", tag, cyc, a);
        fin = 1'b1;
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("%s cyc%0d", tag, cyc), 64'(a), 64'(e));
        if (e.dn) fin = 1'b1;
      end
      if (w_ren) begin obsWren++; if (obsFirstW < 0) obsFirstW = cyc; end
      if (i_ren) begin obsIren++; if (obsFirstI < 0) obsFirstI = cyc; end
      if (psum_ren) obsPren++;
      if (o_wen) begin
        obsOwen++; obsLastO = int'(o_addr); obsMask = o_wmask;
        if (obsFirstO < 0) obsFirstO = cyc;
      end
      if (done) begin obsLen = cyc; obsErr = int'(cfg_err); end
    end
    checkOutput({tag, " finished-in-budget"}, 64'(fin), 64'(1));
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
    #1 checkOutput({tag, " idle-after-done"}, 64'({busy, done}), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; cfg = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 checkOutput("reset outputs", 64'(actSig()), 64'(0));
    checkOutput("reset state", 64'(state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post-reset busy/tile", 64'({busy, tile_idx}), 64'(0));
    checkOutput("post-reset addrs", 64'({w_addr, i_addr, psum_addr, o_addr}), 64'(0));

    // Table: config, job length, cfg_err, enable counts, last mask, last o_addr
    vecs[0] = '{mkCfg(4, 4, 8, 0, 0, 0, 0, 0),       25, 0, 8,  4, 8,  0,  4'b1111, 7};
    vecs[1] = '{mkCfg(2, 10, 3, 510, 0, 0, 100, 0),  52, 0, 9,  6, 9,  0,  4'b0011, 108};
    vecs[2] = '{mkCfg(3, 8, 5, 0, 0, 40, 0, 1),      41, 0, 10, 6, 10, 10, 4'b1111, 9};
    vecs[3] = '{mkCfg(4, 4, 0, 0, 0, 0, 0, 0),       1,  1, 0,  0, 0,  0,  4'b0000, 0};
    vecs[4] = '{mkCfg(4, 20, 4, 0, 0, 0, 0, 0),      1,  1, 0,  0, 0,  0,  4'b0000, 0};
    vecs[5] = '{mkCfg(0, 4, 4, 0, 0, 0, 0, 0),       1,  1, 0,  0, 0,  0,  4'b0000, 0};
    vecs[6] = '{mkCfg(4, 0, 4, 0, 0, 0, 0, 0),       1,  1, 0,  0, 0,  0,  4'b0000, 0};
    vecs[7] = '{mkCfg(1, 16, 1, 0, 0, 0, 0, 0),      57, 0, 4,  4, 4,  0,  4'b1111, 3};
    vecs[8] = '{mkCfg(1, 13, 12, 0, 7, 0, 0, 0),     101, 0, 48, 4, 48, 0, 4'b0001, 47};
    vecs[9] = '{mkCfg(1, 4, 4, 0, 0, 509, 510, 1),   18, 0, 4,  1, 4,  4,  4'b1111, 1};

    for (int v = 0; v < 10; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      applyStimulus(vecs[v].c, 10000, 0, -1, tag);
      checkOutput({tag, " len"},   64'(obsLen),   64'(vecs[v].len));
      checkOutput({tag, " err"},   64'(obsErr),   64'(vecs[v].err));
      checkOutput({tag, " owen"},  64'(obsOwen),  64'(vecs[v].owen));
      checkOutput({tag, " wren"},  64'(obsWren),  64'(vecs[v].wren));
      checkOutput({tag, " iren"},  64'(obsIren),  64'(vecs[v].iren));
      checkOutput({tag, " pren"},  64'(obsPren),  64'(vecs[v].pren));
      checkOutput({tag, " mask"},  64'(obsMask),  64'(vecs[v].mask));
      checkOutput({tag, " lastO"}, 64'(obsLastO), 64'(vecs[v].lastO));
    end

    // First weight read right after start, outputs trail inputs by the array latency
    applyStimulus(mkCfg(4, 4, 8, 0, 0, 0, 0, 0), 10000, 0, -1, "latency");
    checkOutput("latency first w_ren", 64'(obsFirstW), 64'(1));
    checkOutput("latency i_ren->o_wen", 64'(obsFirstO - obsFirstI), 64'(LAT));

    // Five-cycle stall inside IN_OUT plus an ignored start while busy
    applyStimulus(mkCfg(4, 4, 16, 0, 0, 0, 0, 0), 18, 5, 12, "stallInOut");
    checkOutput("stallInOut len", 64'(obsLen), 64'(38));

    // Stall over the DONE cycle defers the done pulse
    applyStimulus(mkCfg(4, 4, 8, 0, 0, 0, 0, 0), 25, 3, -1, "stallDone");
    checkOutput("stallDone len", 64'(obsLen), 64'(28));

    // start together with stall in IDLE is ignored
    @(negedge clk);
    start = 1'b1; stall = 1'b1; cfg = mkCfg(4, 4, 8, 0, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
    #1 checkOutput("stalled start ignored", 64'({busy, state}), 64'({1'b0, IDLE}));

    // Reset in the middle of IN_OUT, then a full clean job
    @(negedge clk);
    start = 1'b1; cfg = mkCfg(4, 4, 16, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 checkOutput("pre-reset state", 64'(state), 64'(IN_OUT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("mid-job reset outputs", 64'(actSig()), 64'(0));
    checkOutput("mid-job reset state", 64'({state, tile_idx, busy}), 64'({IDLE, 2'b00, 1'b0}));
    checkOutput("mid-job reset addrs", 64'({w_addr, i_addr, psum_addr, o_addr}), 64'(0));
    applyStimulus(mkCfg(2, 10, 3, 0, 0, 0, 100, 0), 10000, 0, -1, "afterReset");
    checkOutput("afterReset len", 64'(obsLen), 64'(52));

    // Random jobs against the schedule model
    for (int r = 0; r < 20; r++) begin
      mm_seq_cfg_t rc;
      rc = mkCfg($urandom_range(0, 4), $urandom_range(1, 18), $urandom_range(1, 14),
                 $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                 $urandom_range(0, 511), $urandom_range(0, 1));
      applyStimulus(rc, $urandom_range(2, 40), $urandom_range(0, 4), $urandom_range(2, 30),
                    $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
